// File: rtl/dstack_issue.sv
// dstack_issue: instruction sequencer driving the core0 data stack, with iterative multiply and sticky faults
//   in : clk, reset, op_valid/op_code/op_imm/op_rot, stack taps top/second/third/rot_val, overflow/underflow
//   out: op_ready, movement/next_top/rotate/rot_addr to the stack, fault/fault_code, busy, op_count
module dstack_issue #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    input  logic [4:0]       op_rot,
    input  logic [WIDTH-1:0] top,
    input  logic [WIDTH-1:0] second,
    input  logic [WIDTH-1:0] third,
    input  logic [WIDTH-1:0] rot_val,
    input  logic             overflow,
    input  logic             underflow,
    output logic [1:0]       movement,
    output logic [WIDTH-1:0] next_top,
    output logic             rotate,
    output logic [4:0]       rot_addr,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, MUL, MULWB, HALT} state_t;
    localparam int IW = $clog2(WIDTH + 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] mplier_q, mplier_d, mcand_q, mcand_d, acc_q, acc_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             accept, illegal;

    // Reset forces every visible status output to its idle value, even
    // before the registers have been cleared by the first reset edge.
    assign fault      = fault_q && !reset;
    assign fault_code = reset ? 2'b00 : code_q;
    assign op_count   = reset ? '0 : cnt_q;

    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        code_d   = code_q;
        movement = 2'b00;
        next_top = top;
        rotate   = 1'b0;
        rot_addr = 5'd0;
        illegal  = 1'b0;
        op_ready = (state_q == IDLE) && !reset;
        busy     = ((state_q == MUL) || (state_q == MULWB)) && !reset;
        accept   = op_valid && op_ready;
        if (accept) begin
            case (op_code)
                4'd0: ;
                4'd1: begin movement = 2'b01; next_top = op_imm; end
                4'd2: begin movement = 2'b10; next_top = second; end
                4'd3: begin movement = 2'b11; next_top = third; end
                4'd4: begin movement = 2'b01; next_top = top; end
                4'd5: begin movement = 2'b01; next_top = second; end
                4'd6: begin
                    if (op_rot == 5'd0) begin
                        illegal = 1'b1;
                    end else begin
                        rotate   = 1'b1;
                        rot_addr = op_rot;
                        next_top = rot_val;
                    end
                end
                4'd7:  begin movement = 2'b10; next_top = second + top; end
                4'd8:  begin movement = 2'b10; next_top = second - top; end
                4'd9:  begin movement = 2'b10; next_top = second & top; end
                4'd10: begin movement = 2'b10; next_top = second | top; end
                4'd11: begin movement = 2'b10; next_top = second ^ top; end
                4'd12: begin
                    mplier_d = top;
                    mcand_d  = second;
                    acc_d    = '0;
                    iter_d   = '0;
                    state_d  = MUL;
                end
                default: illegal = 1'b1;
            endcase
            if (illegal) begin
                fault_d = 1'b1;
                code_d  = 2'b11;
                state_d = HALT;
            end else if (op_code != 4'd12) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        case (state_q)
            MUL: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + 1'b1;
                state_d  = (iter_q == IW'(WIDTH - 1)) ? MULWB : MUL;
            end
            MULWB: begin
                movement = 2'b10;
                next_top = acc_q;
                cnt_d    = cnt_q + 1'b1;
                state_d  = IDLE;
            end
            default: ;
        endcase
        // The stack performs the movement regardless; we only record the fault and stop issuing.
        if (movement != 2'b00 && (overflow || underflow)) begin
            fault_d = 1'b1;
            code_d  = overflow ? 2'b01 : 2'b10;
            state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end
endmodule

// File: tb/tb_dstack_issue.sv
// tb_dstack_issue: scoreboard bench for dstack_issue with directed vectors
module tb_dstack_issue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_code = 4'd0;
    logic [31:0] op_imm = '0;
    logic [4:0]  op_rot = '0;
    logic [31:0] top = '0, second = '0, third = '0, rot_val = '0;
    logic        overflow = 1'b0, underflow = 1'b0;
    logic [1:0]  movement;
    logic [31:0] next_top;
    logic        rotate;
    logic [4:0]  rot_addr;
    logic        fault;
    logic [1:0]  fault_code;
    logic        busy;
    logic [15:0] op_count;

    typedef struct packed {
        logic [1:0]  mv;
        logic [31:0] nt;
        logic        ro;
        logic [4:0]  ra;
    } exp_t;
    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    dstack_issue #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_imm(op_imm), .op_rot(op_rot),
        .top(top), .second(second), .third(third), .rot_val(rot_val),
        .overflow(overflow), .underflow(underflow),
        .movement(movement), .next_top(next_top), .rotate(rotate), .rot_addr(rot_addr),
        .fault(fault), .fault_code(fault_code), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: every accepted instruction and every writeback cycle is one scoreboard transaction.
    always @(negedge clk) begin
        if (!reset && ((op_valid && op_ready) || (busy && movement != 2'b00))) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {movement, next_top}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("movement", 64'(movement), 64'(e.mv));
                chk("next_top", 64'(next_top), 64'(e.nt));
                chk("rotate", 64'(rotate), 64'(e.ro));
                chk("rot_addr", 64'(rot_addr), 64'(e.ra));
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] imm, input logic [4:0] r,
                         input logic [31:0] t, input logic [31:0] s, input logic [31:0] th,
                         input logic [31:0] rv, input logic [1:0] mv, input logic [31:0] nt,
                         input logic ro, input logic [4:0] ra);
        op_code = c; op_imm = imm; op_rot = r;
        top = t; second = s; third = th; rot_val = rv;
        op_valid = 1'b1;
        q.push_back(exp_t'{mv, nt, ro, ra});
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic do_reset();
        chk("queue_drained", 64'(q.size()), 64'd0);
        q.delete();
        op_valid = 1'b0; overflow = 1'b0; underflow = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(op_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_code", 64'(fault_code), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_move", 64'({movement, rotate}), 64'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(op_ready), 64'd1);
    endtask

    localparam logic [31:0] T = 32'h0000_00F0, S = 32'h0000_0F3C, TH = 32'h1234_5678, RV = 32'hAAAA_5555;

    initial begin
        int bc;
        @(posedge clk); #1;
        do_reset();
        // PUSH 5, PUSH 7, ADD
        issue(4'd1, 32'd5, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b01, 32'd5, 1'b0, 5'd0);
        issue(4'd1, 32'd7, 5'd0, 32'd5, 32'd0, 32'd0, 32'd0, 2'b01, 32'd7, 1'b0, 5'd0);
        issue(4'd7, 32'd0, 5'd0, 32'd7, 32'd5, 32'd0, 32'd0, 2'b10, 32'd12, 1'b0, 5'd0);
        chk("count_3", 64'(op_count), 64'd3);
        issue(4'd0, 32'd0, 5'd0, T, S, TH, RV, 2'b00, T, 1'b0, 5'd0);
        issue(4'd2, 32'd0, 5'd0, T, S, TH, RV, 2'b10, S, 1'b0, 5'd0);
        issue(4'd3, 32'd0, 5'd0, T, S, TH, RV, 2'b11, TH, 1'b0, 5'd0);
        issue(4'd4, 32'd0, 5'd0, T, S, TH, RV, 2'b01, T, 1'b0, 5'd0);
        issue(4'd5, 32'd0, 5'd0, T, S, TH, RV, 2'b01, S, 1'b0, 5'd0);
        issue(4'd8, 32'd0, 5'd0, T, S, TH, RV, 2'b10, 32'h0000_0E4C, 1'b0, 5'd0);
        issue(4'd9, 32'd0, 5'd0, T, S, TH, RV, 2'b10, 32'h0000_0030, 1'b0, 5'd0);
        issue(4'd10, 32'd0, 5'd0, T, S, TH, RV, 2'b10, 32'h0000_0FFC, 1'b0, 5'd0);
        issue(4'd11, 32'd0, 5'd0, T, S, TH, RV, 2'b10, 32'h0000_0FCC, 1'b0, 5'd0);
        issue(4'd7, 32'd0, 5'd0, 32'd1, 32'hFFFF_FFFF, TH, RV, 2'b10, 32'd0, 1'b0, 5'd0);
        issue(4'd8, 32'd0, 5'd0, 32'd1, 32'd0, TH, RV, 2'b10, 32'hFFFF_FFFF, 1'b0, 5'd0);
        issue(4'd6, 32'd0, 5'd1, T, S, TH, 32'd9, 2'b00, 32'd9, 1'b1, 5'd1);
        issue(4'd6, 32'd0, 5'd31, T, S, TH, RV, 2'b00, RV, 1'b1, 5'd31);
        chk("count_16", 64'(op_count), 64'd16);
        chk("no_fault", 64'(fault), 64'd0);
        // ROT with address 0 is illegal
        issue(4'd6, 32'd0, 5'd0, T, S, TH, RV, 2'b00, T, 1'b0, 5'd0);
        chk("rot0_fault", 64'(fault), 64'd1);
        chk("rot0_code", 64'(fault_code), 64'd3);
        chk("rot0_ready", 64'(op_ready), 64'd0);
        chk("rot0_count", 64'(op_count), 64'd16);
        op_valid = 1'b1; op_code = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("halt_ready", 64'(op_ready), 64'd0);
        chk("halt_count", 64'(op_count), 64'd16);

        // Multiply 3 * 0xFFFFFFFE
        do_reset();
        issue(4'd12, 32'd0, 5'd0, 32'd3, 32'hFFFF_FFFE, TH, RV, 2'b00, 32'd3, 1'b0, 5'd0);
        q.push_back(exp_t'{2'b10, 32'hFFFF_FFFA, 1'b0, 5'd0});
        top = 32'h5A5A_5A5A; second = 32'h0;
        chk("mul_ready_low", 64'(op_ready), 64'd0);
        chk("mul_count0", 64'(op_count), 64'd0);
        bc = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            bc++;
            @(posedge clk); #1;
        end
        chk("mul_busy_cycles", 64'(bc), 64'd33);
        chk("mul_ready_back", 64'(op_ready), 64'd1);
        chk("mul_count1", 64'(op_count), 64'd1);

        // Illegal opcode 13
        issue(4'd13, 32'd0, 5'd0, T, S, TH, RV, 2'b00, T, 1'b0, 5'd0);
        chk("op13_code", 64'(fault_code), 64'd3);
        chk("op13_ready", 64'(op_ready), 64'd0);

        // DROP with underflow
        do_reset();
        underflow = 1'b1;
        issue(4'd2, 32'd0, 5'd0, T, S, TH, RV, 2'b10, S, 1'b0, 5'd0);
        underflow = 1'b0;
        chk("uf_fault", 64'(fault), 64'd1);
        chk("uf_code", 64'(fault_code), 64'd2);
        chk("uf_count", 64'(op_count), 64'd1);
        op_valid = 1'b1; op_code = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("uf_ignored", 64'({op_ready, movement}), 64'd0);
        chk("uf_sticky", 64'(fault_code), 64'd2);

        // PUSH with overflow
        do_reset();
        overflow = 1'b1;
        issue(4'd1, 32'd44, 5'd0, T, S, TH, RV, 2'b01, 32'd44, 1'b0, 5'd0);
        overflow = 1'b0;
        chk("ovf_code", 64'(fault_code), 64'd1);
        chk("ovf_ready", 64'(op_ready), 64'd0);

        // Reset during the multiply aborts writeback
        do_reset();
        issue(4'd12, 32'd0, 5'd0, 32'd5, 32'd7, TH, RV, 2'b00, 32'd5, 1'b0, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy_rst", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_ready", 64'(op_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(op_count), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_wb_count", 64'(op_count), 64'd0);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++)
            issue(4'd0, 32'd0, 5'd0, 32'h11, S, TH, RV, 2'b00, 32'h11, 1'b0, 5'd0);
        chk("count_ffff", 64'(op_count), 64'hFFFF);
        issue(4'd0, 32'd0, 5'd0, 32'h11, S, TH, RV, 2'b00, 32'h11, 1'b0, 5'd0);
        chk("count_wrap", 64'(op_count), 64'd0);

        @(posedge clk); #1;
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
